// File: rtl/trace_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_frame_pkg
// Purpose  : Shared constants for the trace frame receiver: FSM state codes,
//            read-field selects, field size and command byte values.
// Revision : 1.0 - initial release
// ============================================================================
package trace_frame_pkg;

    // Bytes in each of the plaintext / key / ciphertext fields
    localparam int FIELD_BYTES = 16;

    // Command bytes understood by the remote trace streamer
    localparam logic [7:0] CMD_RUN       = 8'd250;
    localparam logic [7:0] CMD_DELAY_MAX = 8'd31;

    // Read-port field selects
    localparam logic [1:0] SEL_PT  = 2'd0;
    localparam logic [1:0] SEL_KEY = 2'd1;
    localparam logic [1:0] SEL_CT  = 2'd2;
    localparam logic [1:0] SEL_SEN = 2'd3;

    // Receiver FSM state encoding
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_CMD_SEND = 4'd1;
    localparam logic [3:0] ST_CMD_WAIT = 4'd2;
    localparam logic [3:0] ST_RX_PT    = 4'd3;
    localparam logic [3:0] ST_RX_KEY   = 4'd4;
    localparam logic [3:0] ST_RX_CT    = 4'd5;
    localparam logic [3:0] ST_RX_SEN   = 4'd6;
    localparam logic [3:0] ST_DONE     = 4'd7;
    localparam logic [3:0] ST_ERR      = 4'd8;

endpackage
`default_nettype wire

// File: rtl/trace_frame_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : trace_frame_rx_if
// Purpose  : Bundles the command, UART byte, read-port and status signals of
//            the trace frame receiver. The master side drives requests and
//            incoming UART traffic; the slave side is the receiver itself.
// Revision : 1.0 - initial release
// ============================================================================
interface trace_frame_rx_if #(
    parameter int ADDR_W = 11
);
    logic              start;
    logic [7:0]        cmd;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic              rx_dv;
    logic [7:0]        rx_byte;
    logic [1:0]        rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              busy;
    logic              frame_done;
    logic              timeout_err;
    logic [ADDR_W:0]   byte_cnt;

    modport master (
        output start, cmd, tx_done, rx_dv, rx_byte, rd_sel, rd_addr,
        input  tx_dv, tx_byte, rd_data, busy, frame_done, timeout_err, byte_cnt
    );

    modport slave (
        input  start, cmd, tx_done, rx_dv, rx_byte, rd_sel, rd_addr,
        output tx_dv, tx_byte, rd_data, busy, frame_done, timeout_err, byte_cnt
    );
endinterface
`default_nettype wire

// File: rtl/trace_sample_ram.sv
`default_nettype none
// ============================================================================
// Module   : trace_sample_ram
// Purpose  : Simple dual-port byte RAM for sensor samples: one write port,
//            one registered read port. Read-during-write returns old data.
// Revision : 1.0 - initial release
// ============================================================================
module trace_sample_ram #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Write port: store one sample byte
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read port: registered, sees the array before this cycle's write
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/trace_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : trace_frame_rx
// Purpose  : Sends one command byte to the trace streamer and captures the
//            returned frame (16 PT, 16 KEY, 16 CT, SAMPLES sensor bytes) into
//            local buffers with a registered read port. An idle-gap timeout
//            aborts a stalled frame.
// Revision : 1.0 - initial release
// ============================================================================
module trace_frame_rx
    import trace_frame_pkg::*;
#(
    parameter int SAMPLES = 2048,
    parameter int ADDR_W  = 11,
    parameter int TIMEOUT = 2000000,
    parameter int TO_W    = 24
) (
    input  logic            clk,
    input  logic            rst,
    trace_frame_rx_if.slave bus
);
    localparam int              c_BC_W       = ADDR_W + 1;
    localparam logic [ADDR_W:0] c_FIELD_LAST = c_BC_W'(FIELD_BYTES - 1);
    localparam logic [ADDR_W:0] c_SEN_LAST   = c_BC_W'(SAMPLES - 1);
    localparam logic [TO_W-1:0] c_TO_LAST    = TO_W'(TIMEOUT - 1);

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic [7:0]        r_cmd;
    logic [ADDR_W:0]   r_byte_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_timeout_err;
    logic [7:0]        r_pt  [FIELD_BYTES];
    logic [7:0]        r_key [FIELD_BYTES];
    logic [7:0]        r_ct  [FIELD_BYTES];
    logic [7:0]        r_small_q;
    logic [1:0]        r_sel_q;
    logic [7:0]        w_ram_q;

    logic w_accept, w_expired, w_field_last, w_sen_last;
    logic w_tx_dv, w_busy, w_frame_done, w_timed;
    logic w_we_pt, w_we_key, w_we_ct, w_we_sen, w_we_any;

    assign w_accept     = (r_state == ST_IDLE) && bus.start;
    assign w_expired    = (r_to_cnt == c_TO_LAST);
    assign w_field_last = (r_byte_cnt == c_FIELD_LAST);
    assign w_sen_last   = (r_byte_cnt == c_SEN_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: a received byte always beats timeout expiry in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (bus.start) w_state_nxt = ST_CMD_SEND;
            ST_CMD_SEND: w_state_nxt = ST_CMD_WAIT;
            ST_CMD_WAIT: begin
                if (bus.tx_done)    w_state_nxt = ST_RX_PT;
                else if (w_expired) w_state_nxt = ST_ERR;
            end
            ST_RX_PT: begin
                if (bus.rx_dv) begin
                    if (w_field_last) w_state_nxt = ST_RX_KEY;
                end else if (w_expired) w_state_nxt = ST_ERR;
            end
            ST_RX_KEY: begin
                if (bus.rx_dv) begin
                    if (w_field_last) w_state_nxt = ST_RX_CT;
                end else if (w_expired) w_state_nxt = ST_ERR;
            end
            ST_RX_CT: begin
                if (bus.rx_dv) begin
                    if (w_field_last) w_state_nxt = ST_RX_SEN;
                end else if (w_expired) w_state_nxt = ST_ERR;
            end
            ST_RX_SEN: begin
                if (bus.rx_dv) begin
                    if (w_sen_last) w_state_nxt = ST_DONE;
                end else if (w_expired) w_state_nxt = ST_ERR;
            end
            ST_DONE:     w_state_nxt = ST_IDLE;
            ST_ERR:      w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs and per-field write enables decoded from the state
    always_comb begin
        w_tx_dv      = (r_state == ST_CMD_SEND);
        w_frame_done = (r_state == ST_DONE);
        w_busy       = (r_state >= ST_CMD_SEND) && (r_state <= ST_RX_SEN);
        w_timed      = (r_state >= ST_CMD_WAIT) && (r_state <= ST_RX_SEN);
        w_we_pt      = (r_state == ST_RX_PT)  && bus.rx_dv;
        w_we_key     = (r_state == ST_RX_KEY) && bus.rx_dv;
        w_we_ct      = (r_state == ST_RX_CT)  && bus.rx_dv;
        w_we_sen     = (r_state == ST_RX_SEN) && bus.rx_dv;
        w_we_any     = w_we_pt || w_we_key || w_we_ct || w_we_sen;
    end

    // Command latch, field byte counter, idle-gap counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd         <= '0;
            r_byte_cnt    <= '0;
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) r_cmd <= bus.cmd;

            if (w_accept || ((r_state == ST_CMD_WAIT) && bus.tx_done)) begin
                r_byte_cnt <= '0;
            end else if (w_we_any) begin
                // the byte that completes a field restarts the count for the next one
                if (w_state_nxt != r_state) r_byte_cnt <= '0;
                else                        r_byte_cnt <= r_byte_cnt + c_BC_W'(1);
            end

            if (!w_timed || bus.rx_dv || (w_state_nxt != r_state)) r_to_cnt <= '0;
            else                                                    r_to_cnt <= r_to_cnt + TO_W'(1);

            if (w_accept)                    r_timeout_err <= 1'b0;
            else if (w_state_nxt == ST_ERR)  r_timeout_err <= 1'b1;
        end
    end

    // Small field arrays: contents survive reset
    always_ff @(posedge clk) begin
        if (w_we_pt)  r_pt[r_byte_cnt[3:0]]  <= bus.rx_byte;
        if (w_we_key) r_key[r_byte_cnt[3:0]] <= bus.rx_byte;
        if (w_we_ct)  r_ct[r_byte_cnt[3:0]]  <= bus.rx_byte;
    end

    // Registered read of the small fields, plus the select delayed to match the RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_q   <= SEL_PT;
            r_small_q <= '0;
        end else begin
            r_sel_q <= bus.rd_sel;
            case (bus.rd_sel)
                SEL_PT:  r_small_q <= r_pt[bus.rd_addr[3:0]];
                SEL_KEY: r_small_q <= r_key[bus.rd_addr[3:0]];
                SEL_CT:  r_small_q <= r_ct[bus.rd_addr[3:0]];
                default: r_small_q <= '0;
            endcase
        end
    end

    trace_sample_ram #(
        .DEPTH (SAMPLES),
        .AW    (ADDR_W)
    ) u_sample_ram (
        .clk     (clk),
        .i_we    (w_we_sen),
        .i_waddr (r_byte_cnt[ADDR_W-1:0]),
        .i_wdata (bus.rx_byte),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_ram_q)
    );

    assign bus.tx_dv       = w_tx_dv;
    assign bus.tx_byte     = r_cmd;
    assign bus.busy        = w_busy;
    assign bus.frame_done  = w_frame_done;
    assign bus.timeout_err = r_timeout_err;
    assign bus.byte_cnt    = r_byte_cnt;
    assign bus.rd_data     = (r_sel_q == SEL_SEN) ? w_ram_q : r_small_q;
endmodule
`default_nettype wire

// File: tb/tb_trace_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_frame_rx
// Purpose  : Self-checking bench for trace_frame_rx. Stimulus pushes expected
//            command bytes, read data and frame/error events into a
//            scoreboard; a monitor pops and compares as the DUT responds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_frame_rx;
    import trace_frame_pkg::*;

    localparam int SAMPLES = 2048;
    localparam int ADDR_W  = 11;
    localparam int TIMEOUT = 32;
    localparam int TO_W    = 24;
    localparam int HDR     = 3 * FIELD_BYTES;
    localparam int FRAME   = HDR + SAMPLES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    trace_frame_rx_if #(.ADDR_W(ADDR_W)) bus ();

    trace_frame_rx #(
        .SAMPLES (SAMPLES),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    int         exp_done = 0;
    int         exp_err  = 0;
    logic       rd_req   = 1'b0;
    logic       rd_pend  = 1'b0;
    logic       prev_err = 1'b0;
    logic [7:0] mon_e;

    // Reference model: the frame as a flat byte image in arrival order
    logic [7:0] m  [FRAME];
    bit         kn [FRAME];

    function automatic int flat(input int sel, input int addr);
        if (sel < 3) return sel * FIELD_BYTES + (addr % FIELD_BYTES);
        return HDR + addr;
    endfunction

    function automatic int exp_cnt(input int n);
        if (n < HDR) return n % FIELD_BYTES;
        return (n - HDR) % SAMPLES;
    endfunction

    function automatic logic [7:0] gen(input int mode, input int k);
        if (mode != 0) return 8'($urandom);
        if (k < 16) return 8'(k);
        if (k < 32) return (k == 31) ? 8'hF0 : 8'(k - 16);
        if (k < 48) return 8'hA0 + 8'(k - 32);
        return 8'(k - HDR);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: read pipeline tracking
    always @(posedge clk) rd_pend <= rd_req;

    // Monitor: pop and compare whenever the DUT presents an output event
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_dv) begin
                n_cmp++;
                if (exp_tx.size() == 0) begin
                    n_bad++;
                    $display("FAIL tx_dv: unexpected strobe with tx_byte %0h", bus.tx_byte);
                end else begin
                    mon_e = exp_tx.pop_front();
                    if (bus.tx_byte !== mon_e) begin
                        n_bad++;
                        $display("FAIL tx_byte: got %0h expected %0h", bus.tx_byte, mon_e);
                    end
                end
            end
            if (rd_pend) begin
                n_cmp++;
                if (exp_rd.size() == 0) begin
                    n_bad++;
                    $display("FAIL rd_data: no expectation queued, got %0h", bus.rd_data);
                end else begin
                    mon_e = exp_rd.pop_front();
                    if (bus.rd_data !== mon_e) begin
                        n_bad++;
                        $display("FAIL rd_data: got %0h expected %0h at %0t", bus.rd_data, mon_e, $time);
                    end
                end
            end
            if (bus.frame_done) begin
                n_cmp++;
                if (exp_done == 0) begin
                    n_bad++;
                    $display("FAIL frame_done: unexpected pulse at %0t", $time);
                end else begin
                    exp_done--;
                    if (bus.busy !== 1'b0) begin
                        n_bad++;
                        $display("FAIL busy_at_done: got %0b expected 0", bus.busy);
                    end
                end
            end
            if (bus.timeout_err && !prev_err) begin
                n_cmp++;
                if (exp_err == 0) begin
                    n_bad++;
                    $display("FAIL timeout_err: unexpected rise at %0t", $time);
                end else begin
                    exp_err--;
                end
            end
            prev_err = bus.timeout_err;
        end
    end

    task automatic issue_start(input logic [7:0] c);
        bit got;
        bus.start = 1'b1;
        bus.cmd   = c;
        exp_tx.push_back(c);
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 1);
        chk("terr_cleared", 32'(bus.timeout_err), 0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (bus.tx_dv) got = 1'b1;
            else tick();
        end
        chk("tx_dv_seen", 32'(got), 1);
        repeat ($urandom_range(1, 5)) tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic send_byte(input int k, input logic [7:0] b, input int gap,
                             input int fsel, input int faddr);
        int sel;
        int addr;
        int ix;
        sel  = (fsel < 0) ? int'($urandom_range(0, 3)) : fsel;
        addr = (fsel < 0) ? int'($urandom_range(0, SAMPLES - 1)) : faddr;
        ix   = flat(sel, addr);
        bus.rx_dv   = 1'b1;
        bus.rx_byte = b;
        bus.rd_sel  = 2'(sel);
        bus.rd_addr = ADDR_W'(addr);
        if (kn[ix]) begin
            rd_req = 1'b1;
            exp_rd.push_back(m[ix]);
        end
        m[k]  = b;
        kn[k] = 1'b1;
        tick();
        bus.rx_dv = 1'b0;
        rd_req    = 1'b0;
        chk("byte_cnt", 32'(bus.byte_cnt), 32'(exp_cnt(k + 1)));
        repeat (gap) tick();
    endtask

    task automatic feed(input int mode, input int k0, input int k1);
        int fsel;
        int faddr;
        for (int k = k0; k < k1; k++) begin
            fsel  = -1;
            faddr = 0;
            if (k == 20)  begin fsel = 0; faddr = 5;   end
            if (k == 148) begin fsel = 3; faddr = 100; end
            if (k == FRAME - 1) exp_done++;
            send_byte(k, gen(mode, k), (k == k1 - 1) ? 0 : int'($urandom_range(0, 3)), fsel, faddr);
        end
    endtask

    task automatic do_read(input int sel, input int addr);
        int ix;
        ix = flat(sel, addr);
        bus.rd_sel  = 2'(sel);
        bus.rd_addr = ADDR_W'(addr);
        if (kn[ix]) begin
            rd_req = 1'b1;
            exp_rd.push_back(m[ix]);
        end
        tick();
        rd_req = 1'b0;
    endtask

    task automatic read_all();
        for (int s = 0; s < 3; s++)
            for (int a = 0; a < FIELD_BYTES; a++) do_read(s, a);
        do_read(int'(SEL_SEN), 0);
        do_read(int'(SEL_SEN), SAMPLES - 1);
        for (int i = 0; i < 32; i++) do_read(int'(SEL_SEN), int'($urandom_range(0, SAMPLES - 1)));
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_dv"},       32'(bus.tx_dv), 0);
        chk({tag, "_tx_byte"},     32'(bus.tx_byte), 0);
        chk({tag, "_rd_data"},     32'(bus.rd_data), 0);
        chk({tag, "_busy"},        32'(bus.busy), 0);
        chk({tag, "_frame_done"},  32'(bus.frame_done), 0);
        chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
        chk({tag, "_byte_cnt"},    32'(bus.byte_cnt), 0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.cmd     = '0;
        bus.tx_done = 1'b0;
        bus.rx_dv   = 1'b0;
        bus.rx_byte = '0;
        bus.rd_sel  = '0;
        bus.rd_addr = '0;
        for (int i = 0; i < FRAME; i++) kn[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Frame 1: run command, fixed pattern
        issue_start(CMD_RUN);
        feed(0, 0, FRAME);
        tick();
        chk("frame1_done_seen", 32'(exp_done), 0);
        chk("frame1_busy_low", 32'(bus.busy), 0);
        read_all();

        // Frame 2: delay command, random stream
        issue_start(8'd17);
        feed(1, 0, FRAME);
        tick();
        chk("frame2_done_seen", 32'(exp_done), 0);
        read_all();

        // Frame 3: overwrite with another random stream
        issue_start(CMD_DELAY_MAX);
        feed(1, 0, FRAME);
        tick();
        chk("frame3_done_seen", 32'(exp_done), 0);
        chk("frame3_no_err", 32'(bus.timeout_err), 0);

        // Bytes arriving while idle must be ignored
        for (int i = 0; i < 8; i++) begin
            bus.rx_dv   = 1'b1;
            bus.rx_byte = 8'($urandom);
            tick();
            bus.rx_dv = 1'b0;
        end
        chk("idle_byte_cnt", 32'(bus.byte_cnt), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        read_all();

        // Stall after 40 bytes: error exactly TIMEOUT idle cycles later
        issue_start(CMD_RUN);
        feed(1, 0, 40);
        exp_err++;
        repeat (TIMEOUT - 1) tick();
        chk("stall_err_not_yet", 32'(bus.timeout_err), 0);
        chk("stall_busy_still", 32'(bus.busy), 1);
        tick();
        chk("stall_err_set", 32'(bus.timeout_err), 1);
        chk("stall_busy_low", 32'(bus.busy), 0);
        repeat (3) tick();
        chk("stall_err_sticky", 32'(bus.timeout_err), 1);
        read_all();

        // Byte coinciding with expiry wins; start while busy is ignored
        issue_start(8'd5);
        feed(1, 0, 21);
        send_byte(21, gen(1, 21), TIMEOUT - 1, -1, 0);
        feed(1, 22, 500);
        bus.start = 1'b1;
        bus.cmd   = 8'h33;
        tick();
        bus.start = 1'b0;
        chk("busy_start_ignored", 32'(bus.busy), 1);
        feed(1, 500, FRAME);
        tick();
        chk("coincide_done_seen", 32'(exp_done), 0);
        chk("coincide_no_err", 32'(bus.timeout_err), 0);
        read_all();

        // Asynchronous reset mid sensor capture
        issue_start(CMD_RUN);
        feed(1, 0, HDR + 500);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Clean frame after reset
        issue_start(CMD_RUN);
        feed(0, 0, FRAME);
        tick();
        chk("final_done_seen", 32'(exp_done), 0);
        read_all();

        chk("tx_queue_drained", 32'(exp_tx.size()), 0);
        chk("rd_queue_drained", 32'(exp_rd.size()), 0);
        chk("err_events_drained", 32'(exp_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #3000000;
        n_bad++;
        $display("FAIL watchdog: run still active at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/trace_frame_rx.md
Name: trace_frame_rx

Overview:
- Host-side counterpart of the on-chip-sensor trace streamer.
- Issues a one-byte command over a UART TX byte interface: 250 means "run next encryption"; 0..31 means "set delay".
- Parses the returned byte stream in fixed order: 16 plaintext, 16 key, 16 ciphertext, SAMPLES sensor bytes.
- Stores each field in local buffers with a registered read port, for a second FPGA or a loopback test harness sitting on the uart_rx/uart_tx pair.

Parameters:
- SAMPLES, 2048, number of sensor bytes per frame.
- ADDR_W, 11, sensor buffer address width (2**ADDR_W >= SAMPLES).
- TIMEOUT, 2000000, idle clk cycles allowed between received bytes (and after the command) before abort.
- TO_W, 24, timeout counter width.

Ports:
- clk  in  1  system clock (same domain as the uart_tx/uart_rx byte interfaces).
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to send cmd and capture one frame.
- cmd  in  8  command byte, sampled on the start cycle.
- tx_dv  out  1  single-cycle strobe to uart_tx.
- tx_byte  out  8  byte to uart_tx.
- tx_done  in  1  uart_tx completion pulse.
- rx_dv  in  1  uart_rx byte-valid pulse.
- rx_byte  in  8  uart_rx byte.
- rd_sel  in  2  read field select: 0 = PT, 1 = KEY, 2 = CT, 3 = SENSOR.
- rd_addr  in  ADDR_W  read index (PT/KEY/CT use bits [3:0]).
- rd_data  out  8  registered read data.
- busy  out  1  high from the accepted start until DONE/ERR.
- frame_done  out  1  single-cycle pulse when the full frame is captured.
- timeout_err  out  1  sticky abort flag; cleared by the next accepted start.
- byte_cnt  out  ADDR_W+1  bytes stored in the current field.

Behaviour:
- Reset values: tx_dv = 0, tx_byte = 0, rd_data = 0, busy = 0, frame_done = 0, timeout_err = 0, byte_cnt = 0, state = IDLE. Buffer contents are not cleared by reset.
- Reset is asynchronous and honoured mid-operation: the FSM returns to IDLE immediately and any partial frame is abandoned.
- States:
  - IDLE: start=1 latches cmd, sets busy=1, clears timeout_err, goes to CMD_SEND. rx_dv in IDLE is ignored. start while busy is ignored.
  - CMD_SEND: tx_dv=1 for exactly one cycle with tx_byte=cmd, then CMD_WAIT.
  - CMD_WAIT: wait for tx_done=1, then RX_PT with byte_cnt=0 and the timeout counter cleared.
  - RX_PT, RX_KEY, RX_CT: each rx_dv writes rx_byte to the field at byte_cnt, then byte_cnt+1. The write that makes byte_cnt reach 16 advances to the next state and resets byte_cnt to 0.
  - RX_SEN: same rule, advancing to DONE when byte_cnt reaches SAMPLES.
  - DONE: one cycle; frame_done=1, busy=0, then IDLE.
  - ERR: one cycle; timeout_err=1 (held), busy=0, then IDLE.
- Timeout:
  - The counter runs in CMD_WAIT and all RX states and clears on every rx_dv or state change.
  - Reaching TIMEOUT-1 enters ERR.
  - If rx_dv and expiry coincide, the byte wins: it is stored and the counter clears.
  - TIMEOUT must exceed the 1024-cycle encryption wait of the remote device plus one UART byte time.
- Field order is fixed; there is no framing byte. Byte order is MSB-first, so PT[0] = Din[127:120] of the remote device.
- Read port:
  - rd_data = buf[rd_sel][rd_addr], one-cycle latency.
  - Reads are legal at any time, including during capture; they return the current (possibly partial) content.
  - A read and a write to the same address in the same cycle returns the old data.
- The sensor buffer is inferred block RAM (SAMPLES x 8, one write port, one read port). PT/KEY/CT are 16x8 register arrays.
- byte_cnt width is ADDR_W+1 so that the value SAMPLES is representable.

Decomposition:
- Package trace_frame_pkg holds:
  - state encoding localparams;
  - field select constants (SEL_PT, SEL_KEY, SEL_CT, SEL_SEN);
  - FIELD_BYTES = 16;
  - command constants CMD_RUN = 250 and CMD_DELAY_MAX = 31.
- Sub-module trace_sample_ram: simple dual-port SAMPLES x 8 RAM with registered read. The 16-byte arrays stay inline.

Test Plan:
- start with cmd=250 -> single tx_dv with tx_byte=0xFA. After tx_done, feed PT 0x00..0x0F, KEY 0x00,0x01,..,0x0E,0xF0, CT 0xA0..0xAF, sensor bytes = index[7:0] for 2048 bytes -> frame_done pulses once after byte 2096, busy falls, and reads return the fed values (rd_sel=3, rd_addr=2047 -> 0xFF).
- cmd=17 -> tx_byte=0x11. Full frame follows. Then a second start with a different stream -> buffers are overwritten and timeout_err stays 0.
- Stream stalls after 40 bytes (CT index 7) -> ERR after TIMEOUT cycles: timeout_err=1, busy=0, frame_done never pulses. The next start clears timeout_err.
- rx_dv on the same cycle as the timeout count reaching TIMEOUT-1 -> byte stored, no ERR. start pulsed while busy -> no second tx_dv. rx_dv in IDLE -> buffers unchanged.
- Assert rst during RX_SEN at byte 500 -> all outputs return to reset values immediately. A new start then captures a clean frame.
- Read rd_sel=0, rd_addr=5 during capture -> rd_data valid one cycle later. Read and write to the same sensor address in one cycle -> old value returned.
